// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller for four requesters sharing one resource.
// Drives an external 2-bit loadable counter used as the priority pointer.
module rr_grant_ctrl #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] done,
   input  logic       cfg_ld,
   input  logic [1:0] cfg_ptr,
   input  logic [1:0] ptr_val,
   input  logic       ptr_cout,
   output logic       ptr_ld,
   output logic       ptr_inc,
   output logic [1:0] ptr_ld_val,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       timeout,
   output logic [7:0] rounds
);

   typedef enum logic [1:0] {IDLE, SCAN, GRANT, RELEASE} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t     state, state_nx;
   logic [3:0] hold;
   logic       grant_now;
   logic       forced;

   assign ptr_ld_val = cfg_ptr;

   always_comb begin
      state_nx  = state;
      ptr_ld    = 1'b0;
      ptr_inc   = 1'b0;
      grant_now = 1'b0;
      forced    = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_ld)
               ptr_ld = 1'b1;
            else if (req != 4'b0000)
               state_nx = SCAN;
         end
         SCAN: begin
            if (req[ptr_val]) begin
               state_nx  = GRANT;
               grant_now = 1'b1;
            end else if (req == 4'b0000) begin
               state_nx = IDLE;
            end else begin
               ptr_inc = 1'b1;
            end
         end
         GRANT: begin
            // done takes precedence over expiry, so a coincident done is never a timeout
            if (done[gnt_id]) begin
               state_nx = RELEASE;
            end else if (hold == HOLD_LAST) begin
               state_nx = RELEASE;
               forced   = 1'b1;
            end
         end
         RELEASE: begin
            ptr_inc  = 1'b1;
            state_nx = (req != 4'b0000) ? SCAN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_id  <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
         rounds  <= '0;
         hold    <= '0;
      end else begin
         state   <= state_nx;
         busy    <= (state_nx == GRANT);
         timeout <= forced;
         if (grant_now) begin
            gnt    <= 4'b0001 << ptr_val;
            gnt_id <= ptr_val;
            hold   <= '0;
         end else begin
            if (state_nx != GRANT)
               gnt <= '0;
            if (state == GRANT)
               hold <= hold + 4'd1;
         end
         if (ptr_inc && ptr_cout)
            rounds <= rounds + 8'd1;
      end
   end

endmodule
